renkon_ctrl_relu: RTL and testbench

//  Sequencer for the renkon ReLU output stage. On a start request it streams
//  N pixels through the ReLU pipe: read-enable/address to the source buffer,

---
 rtl/renkon_ctrl_relu.sv | 170 +++++++++++++++++
 tb/tb_renkon_ctrl_relu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/renkon_ctrl_relu.sv
// renkon_ctrl_relu: sequencer for the renkon ReLU output stage.
// It accepts a start request and issues one source read per cycle for N
// pixels. A valid/index shift pipe lines up the ReLU out_en and the
// destination write with each read. A one-cycle ack follows the last write.
module renkon_ctrl_relu #(
  parameter int AWIDTH   = 12,
  parameter int RD_LAT   = 1,
  parameter int RELU_LAT = 2
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [AWIDTH-1:0] total,
  input  logic [AWIDTH-1:0] src_base,
  input  logic [AWIDTH-1:0] dst_base,
  output logic              src_re,
  output logic [AWIDTH-1:0] src_addr,
  output logic              relu_oe,
  output logic              dst_we,
  output logic [AWIDTH-1:0] dst_addr,
  output logic              busy,
  output logic              ack
);

  // Pipe stage j holds the read issued j+1 cycles earlier. The last stage
  // feeds the write. The stage RELU_LAT-1 places before it feeds out_en.
  localparam int VDEPTH = RD_LAT + RELU_LAT - 1;
  localparam logic [AWIDTH-1:0] ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] ZERO = {AWIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   total_q, total_d;
  logic [AWIDTH-1:0]   dst_base_q, dst_base_d;
  logic [AWIDTH-1:0]   k_q, k_d;
  logic                src_re_q, src_re_d;
  logic [AWIDTH-1:0]   src_addr_q, src_addr_d;
  logic [VDEPTH-1:0]   vld_q, vld_d;
  logic [AWIDTH-1:0]   idx_q [VDEPTH];
  logic [AWIDTH-1:0]   idx_d [VDEPTH];
  logic                relu_oe_q, relu_oe_d;
  logic                dst_we_q, dst_we_d;
  logic [AWIDTH-1:0]   dst_addr_q, dst_addr_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;

  // Next-state logic for the FSM, the read issue and the alignment pipes.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    dst_base_d = dst_base_q;
    k_d        = k_q;
    src_re_d   = 1'b0;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;

    // Shift the valid/index pipes every cycle; idle cycles shift in zeros.
    vld_d    = {vld_q[VDEPTH-2:0], src_re_q};
    idx_d[0] = k_q;
    for (int i = 1; i < VDEPTH; i++) begin
      idx_d[i] = idx_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          total_d    = total;
          dst_base_d = dst_base;
          if (total != ZERO) begin
            state_d    = RUN;
            src_re_d   = 1'b1;
            src_addr_d = src_base;
            k_d        = ZERO;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The current cycle carries read k_q. Stop once pixel N-1 is out.
        if (k_q == (total_q - ONE)) begin
          state_d = DRAIN;
        end else begin
          src_re_d   = 1'b1;
          k_d        = k_q + ONE;
          src_addr_d = src_addr_q + ONE;
        end
      end
      DRAIN: begin
        // The last write is the one with nothing left behind it in the pipe.
        if (dst_we_q && (vld_q == {VDEPTH{1'b0}})) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    relu_oe_d = vld_q[VDEPTH-RELU_LAT];
    dst_we_d  = vld_q[VDEPTH-1];
    if (vld_q[VDEPTH-1]) begin
      dst_addr_d = dst_base_q + idx_q[VDEPTH-1];
    end else begin
      dst_addr_d = dst_addr_q;
    end

    busy_d = (state_d != IDLE);
    ack_d  = (state_d == DONE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q    <= IDLE;
      total_q    <= ZERO;
      dst_base_q <= ZERO;
      k_q        <= ZERO;
      src_re_q   <= 1'b0;
      src_addr_q <= ZERO;
      vld_q      <= {VDEPTH{1'b0}};
      for (int i = 0; i < VDEPTH; i++) begin
        idx_q[i] <= ZERO;
      end
      relu_oe_q  <= 1'b0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= ZERO;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      dst_base_q <= dst_base_d;
      k_q        <= k_d;
      src_re_q   <= src_re_d;
      src_addr_q <= src_addr_d;
      vld_q      <= vld_d;
      for (int i = 0; i < VDEPTH; i++) begin
        idx_q[i] <= idx_d[i];
      end
      relu_oe_q  <= relu_oe_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign src_re   = src_re_q;
  assign src_addr = src_addr_q;
  assign relu_oe  = relu_oe_q;
  assign dst_we   = dst_we_q;
  assign dst_addr = dst_addr_q;
  assign busy     = busy_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_renkon_ctrl_relu.sv
// Testbench for renkon_ctrl_relu. It includes a behavioural source memory,
// a ReLU unit and a destination memory. Every cycle of each operation is
// checked against the expected timing of the operation.
module tb_renkon_ctrl_relu;

  localparam int AW     = 12;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          xrst;
  logic          req;
  logic [AW-1:0] total, src_base, dst_base;
  logic          src_re, relu_oe, dst_we, busy, ack;
  logic [AW-1:0] src_addr, dst_addr;

  int checks = 0;
  int errors = 0;

  logic [15:0] src_mem [0:4095];
  logic [15:0] dst_mem [0:4095];
  logic [15:0] rdata, relu_in, relu_out;

  // Addresses the DUT is expected to be holding when its enables are low.
  logic [AW-1:0] hold_src, hold_dst;

  renkon_ctrl_relu #(.AWIDTH(AW), .RD_LAT(RD_LAT), .RELU_LAT(2)) dut (
    .clk(clk), .xrst(xrst), .req(req), .total(total),
    .src_base(src_base), .dst_base(dst_base),
    .src_re(src_re), .src_addr(src_addr), .relu_oe(relu_oe),
    .dst_we(dst_we), .dst_addr(dst_addr), .busy(busy), .ack(ack)
  );

  always #5 clk = ~clk;

  // Datapath model: read latency of one cycle, a ReLU input register,
  // a ReLU output register loaded on out_en, and the destination write.
  always @(posedge clk) begin
    if (src_re) rdata <= src_mem[src_addr];
    relu_in <= rdata;
    if (relu_oe) relu_out <= relu_in[15] ? 16'h0000 : relu_in;
    if (dst_we) dst_mem[dst_addr] <= relu_out;
  end

  function automatic logic [15:0] relu_f(input logic [15:0] x);
    return x[15] ? 16'h0000 : x;
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b000, src_re, src_addr, relu_oe, dst_we, dst_addr, busy, ack};
  endfunction

  // Run one operation starting in the current (idle) cycle. The expected
  // value of every output is derived from the cycle offset c after req.
  // rep > 0 re-pulses req with different operands at cycle rep.
  task automatic run_op(input int n, input logic [AW-1:0] sb,
                        input logic [AW-1:0] db, input int rep,
                        output int ack_seen, output logic [AW-1:0] lsrc,
                        output logic [AW-1:0] ldst);
    int  ncyc;
    logic e_sre, e_oe, e_we, e_busy, e_ack;
    ack_seen = -1;
    lsrc     = 12'h000;
    ldst     = 12'h000;
    ncyc     = (n == 0) ? 1 : n + RD_LAT + 3;
    req = 1'b1; total = 12'(n); src_base = sb; dst_base = db;
    for (int c = 1; c <= ncyc + 1; c++) begin
      @(posedge clk); #1;
      if (c == rep) begin
        req = 1'b1; total = 12'(n + 5); src_base = sb + 12'h003;
        dst_base = db + 12'h007;
      end else begin
        req = 1'b0;
      end
      e_sre = (n > 0) && (c <= n);
      e_oe  = (n > 0) && (c >= RD_LAT + 2) && (c <= n + RD_LAT + 1);
      e_we  = (n > 0) && (c >= RD_LAT + 3) && (c <= n + RD_LAT + 2);
      e_ack = (c == ncyc);
      e_busy = (c <= ncyc);
      if (e_sre) hold_src = sb + 12'(c - 1);
      if (e_we)  hold_dst = db + 12'(c - RD_LAT - 3);
      chk("cycle", c, outs(),
          {3'b000, e_sre, hold_src, e_oe, e_we, hold_dst, e_busy, e_ack});
      if (ack) ack_seen = c;
      if (src_re) lsrc = src_addr;
      if (dst_we) ldst = dst_addr;
    end
    for (int k = 0; k < n; k++) begin
      chk("data", k, {16'h0000, dst_mem[db + 12'(k)]},
          {16'h0000, relu_f(src_mem[sb + 12'(k)])});
    end
  endtask

  typedef struct {
    int            n;
    logic [AW-1:0] sb;
    logic [AW-1:0] db;
    int            rep;
    int            ack_c;
    logic [AW-1:0] lsrc;
    logic [AW-1:0] ldst;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int            ack_seen;
    logic [AW-1:0] lsrc, ldst;

    tbl[0] = '{4, 12'h010, 12'h200, 0, 8,  12'h013, 12'h203};
    tbl[1] = '{0, 12'h0AA, 12'h0BB, 0, 1,  12'h000, 12'h000};
    tbl[2] = '{4, 12'hFFE, 12'h100, 0, 8,  12'h001, 12'h103};
    tbl[3] = '{7, 12'hFF0, 12'hFFD, 0, 11, 12'hFF6, 12'h003};
    tbl[4] = '{1, 12'h123, 12'h456, 0, 5,  12'h123, 12'h456};
    tbl[5] = '{4, 12'h020, 12'h220, 2, 8,  12'h023, 12'h223};

    for (int i = 0; i < 4096; i++) src_mem[i] = 16'($urandom);
    xrst = 1'b1; req = 1'b0; total = 12'h000; src_base = 12'h000;
    dst_base = 12'h000; hold_src = 12'h000; hold_dst = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 0, outs(), 32'h0);
    xrst = 1'b0;
    @(posedge clk); #1;
    chk("idle", 0, outs(), 32'h0);

    // Directed table: normal, empty, wrapping, and re-pulsed operations.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].n, tbl[i].sb, tbl[i].db, tbl[i].rep, ack_seen, lsrc, ldst);
      chk("ack_cycle", i, 32'(ack_seen), 32'(tbl[i].ack_c));
      if (tbl[i].n > 0) begin
        chk("last_src", i, {20'h0, lsrc}, {20'h0, tbl[i].lsrc});
        chk("last_dst", i, {20'h0, ldst}, {20'h0, tbl[i].ldst});
      end
    end

    // A single pixel rerun with positive, negative, then positive data.
    src_mem[12'h0A0] = 16'd7;
    run_op(1, 12'h0A0, 12'h0B0, 0, ack_seen, lsrc, ldst);
    chk("relu_pos", 0, {16'h0, dst_mem[12'h0B0]}, 32'd7);
    src_mem[12'h0A0] = 16'hFFFB;
    run_op(1, 12'h0A0, 12'h0B0, 0, ack_seen, lsrc, ldst);
    chk("relu_neg", 0, {16'h0, dst_mem[12'h0B0]}, 32'd0);
    chk("relu_addr", 0, {20'h0, ldst}, 32'h0B0);
    src_mem[12'h0A0] = 16'd7;
    run_op(1, 12'h0A0, 12'h0B0, 0, ack_seen, lsrc, ldst);
    chk("relu_pos2", 0, {16'h0, dst_mem[12'h0B0]}, 32'd7);
    chk("relu_addr2", 0, {20'h0, ldst}, 32'h0B0);

    // Reset in the middle of RUN aborts the operation with no further enables.
    req = 1'b1; total = 12'd10; src_base = 12'h300; dst_base = 12'h400;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
    end
    xrst = 1'b1;
    @(posedge clk); #1;
    xrst = 1'b0;
    hold_src = 12'h000; hold_dst = 12'h000;
    chk("abort", 0, outs(), 32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk("post_abort", c, outs(), 32'h0);
    end
    run_op(3, 12'h300, 12'h400, 0, ack_seen, lsrc, ldst);
    chk("restart_ack", 0, 32'(ack_seen), 32'd7);

    // Random operations with bases anywhere in the address space.
    for (int i = 0; i < 30; i++) begin
      int n;
      n = $urandom_range(0, 20);
      run_op(n, 12'($urandom), 12'($urandom), $urandom_range(0, 4),
             ack_seen, lsrc, ldst);
      chk("rand_ack", i, 32'(ack_seen), (n == 0) ? 32'd1 : 32'(n + RD_LAT + 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
